f_fetch_ctrl: RTL and testbench
===============================

Name: f_fetch_ctrl

Overview:
- F-stage fetch sequencer. Owns the fetch PC register and drives a single-outstanding request/response instruction-memory port.
- Presents fetched instructions to D through a valid/ready handshake.
- Applies next-PC redirects (branch/jump/jr targets computed in D) with MIPS delay-slot semantics: the instruction already being fetched when a redirect arrives is still delivered.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- npc_in  in  32  redirect target from D-stage next-PC logic; bits [1:0] ignored.
- redirect  in  1  one-cycle pulse: D instruction is a taken branch/jump; npc_in valid this cycle.
- ready_d  in  1  D can accept an instruction this cycle (not stalled).
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address; bits [1:0] always 2'b00.
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- valid_f  out  1  instr_f/pc_f hold a valid instruction for D.
- instr_f  out  32  fetched instruction.
- pc_f  out  32  address of instr_f.

Behaviour:
- All outputs are registered, except imem_req and imem_addr, which decode from state and pc.
- Registers:
  - pc[31:0]
  - state (REQ, WAIT, HOLD)
  - instr_buf[31:0]
  - pc_f[31:0]
  - pend_valid
  - pend_target[31:0]
- Reset (reset==0 at posedge):
  - pc=RESET_PC, state=REQ
  - valid_f=0, instr_f=0, pc_f=0
  - pend_valid=0, pend_target=0
  - Reset overrides every other input the same edge.
- REQ: imem_req=1, imem_addr={pc[31:2],2'b00}.
  - imem_gnt=1 -> WAIT.
  - imem_gnt=0 -> stay in REQ with address held stable.
- WAIT: imem_req=0.
  - imem_rvalid=1 -> instr_f<=imem_rdata, pc_f<=pc, valid_f<=1, state->HOLD.
- HOLD: valid_f=1, instr_f and pc_f stable.
  - ready_d=1 -> transfer occurs this cycle; valid_f<=0, pc<=next_pc, state->REQ.
  - ready_d=0 -> hold indefinitely.
- imem_rvalid outside WAIT and imem_gnt outside REQ are ignored.
- next_pc priority at the HOLD transfer edge:
  1. redirect this cycle -> npc_in
  2. pend_valid -> pend_target
  3. otherwise pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
- Clearing low bits: next_pc[1:0] forced to 2'b00.
- Redirect in any cycle not consumed by a HOLD transfer:
  - pend_target<=npc_in, pend_valid<=1.
  - A later redirect before consumption overwrites it (latest wins).
- Redirect consumption: a HOLD transfer clears pend_valid, whether it consumed the pending target or a same-cycle redirect.
- Delay slot: the instruction in REQ/WAIT/HOLD when a redirect arrives is delivered unchanged; the redirect steers only the following fetch.
- Latency: reset release to first imem_req is 0 cycles (REQ combinational from reset state).
- Minimum issue interval is 3 cycles: REQ(gnt) -> WAIT(rvalid) -> HOLD(ready_d).
- Reset mid-operation: any outstanding request is abandoned; the memory is reset on the same reset, so no stale rvalid is expected.

Decomposition:
- Shared package constants:
  - fetch state encodings FS_REQ=2'd0, FS_WAIT=2'd1, FS_HOLD=2'd2
  - RESET_PC default 32'h0000_3000
  - NPC op codes (PlusFour 3'b000, Branch 3'b001, Jump 3'b010, JumpReg 3'b011) shared with D-stage NPC logic
- One natural sub-module: f_redirect_buf, the pend_valid/pend_target register with latest-wins capture and consume-clear.

Test Plan:
1. Reset release, memory gnt and rvalid each 1 cycle after request, ready_d=1 -> imem_addr sequence 3000,3004,3008; pc_f 3000,3004,3008; one instruction per 3 cycles.
2. At 3004 in HOLD, ready_d=1 with redirect=1, npc_in=32'h0000_3100 -> next imem_addr=3100; no 3008 fetch.
3. redirect=1, npc_in=3200 pulsed in WAIT of fetch 3008 -> 3008 still delivered (delay slot), then next imem_addr=3200, pend_valid cleared.
4. ready_d=0 for 5 cycles in HOLD -> valid_f=1, instr_f/pc_f stable, imem_req=0; on release -> pc+4 fetched.
5. Two redirects (3300 then 3400) before a transfer; npc_in=32'h0000_3403 -> fetch address 3400 (latest wins, low bits cleared).
6. reset=0 asserted in WAIT with pend_valid=1 -> next cycle state REQ, imem_addr=3000, valid_f=0, pend_valid=0; a pc of FFFFFFFC advances to 00000000.

Source files
------------

// File: rtl/f_fetch_ctrl_pkg.sv
// Shared definitions for the F-stage fetch sequencer and its D-stage partners.
package f_fetch_ctrl_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // Next-PC operation codes, common with the D-stage NPC logic
  typedef enum logic [2:0] {
    NPC_PLUS4   = 3'b000,
    NPC_BRANCH  = 3'b001,
    NPC_JUMP    = 3'b010,
    NPC_JUMPREG = 3'b011
  } npc_op_e;

  // Source selected for the next fetch address at a HOLD transfer
  typedef enum logic [1:0] {
    NSEL_SEQ      = 2'd0,
    NSEL_REDIRECT = 2'd1,
    NSEL_PENDING  = 2'd2
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Force an address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential successor; wraps naturally at 2^32
  function automatic logic [31:0] seq_pc(input logic [31:0] addr);
    return word_align(addr) + PC_STEP;
  endfunction

endpackage

// File: rtl/f_redirect_buf.sv
// Holds a redirect target that arrived while no HOLD transfer could consume it.
// The most recent redirect wins; a transfer clears the entry.
module f_redirect_buf
  import f_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] npc_in,
  input  logic        consume,
  output logic        pend_valid,
  output logic [31:0] pend_target
);

  // Capture unconsumed redirects; a same-cycle transfer takes precedence
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (consume) begin
      pend_valid  <= 1'b0;
    end else if (redirect) begin
      pend_valid  <= 1'b1;
      pend_target <= npc_in;
    end
  end

endmodule

// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: owns the fetch PC, issues one outstanding
// instruction-memory request at a time and hands results to D via valid/ready.
// Redirects follow delay-slot semantics: the fetch in flight is still delivered.
module f_fetch_ctrl
  import f_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        redirect,
  input  logic        ready_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  instr_buf;
  logic         transfer;
  logic         pend_valid;
  logic [31:0]  pend_target;
  npc_sel_e     npc_sel;
  logic [31:0]  next_pc;

  assign transfer = (state == FS_HOLD) && ready_d;
  assign instr_f  = instr_buf;

  f_redirect_buf u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .npc_in      (npc_in),
    .consume     (transfer),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  // Memory port decodes straight from state so REQ is visible right out of reset
  always_comb begin
    imem_req  = (state == FS_REQ);
    imem_addr = word_align(pc);
  end

  // Next-PC source: same-cycle redirect, then pending target, then pc+4
  always_comb begin
    npc_sel = NSEL_SEQ;
    if (redirect)
      npc_sel = NSEL_REDIRECT;
    else if (pend_valid)
      npc_sel = NSEL_PENDING;

    unique case (npc_sel)
      NSEL_REDIRECT: next_pc = word_align(npc_in);
      NSEL_PENDING:  next_pc = word_align(pend_target);
      default:       next_pc = seq_pc(pc);
    endcase
  end

  // Fetch FSM with registered D-side outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FS_REQ;
      pc        <= word_align(RESET_PC);
      valid_f   <= 1'b0;
      instr_buf <= '0;
      pc_f      <= '0;
    end else begin
      unique case (state)
        FS_REQ: begin
          if (imem_gnt)
            state <= FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rvalid) begin
            instr_buf <= imem_rdata;
            pc_f      <= pc;
            valid_f   <= 1'b1;
            state     <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (ready_d) begin
            valid_f <= 1'b0;
            pc      <= next_pc;
            state   <= FS_REQ;
          end
        end
        default: state <= FS_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Scoreboard bench for f_fetch_ctrl: expected fetch addresses and delivered
// PCs are queued as stimulus is driven and popped when the DUT presents them.
module tb_f_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_in;
  logic        redirect;
  logic        ready_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_f;
  logic [31:0] instr_f;
  logic [31:0] pc_f;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc_cnt = 0;
  int unsigned last_start = 0;
  bit          have_last = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  f_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .npc_in      (npc_in),
    .redirect    (redirect),
    .ready_d     (ready_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .valid_f     (valid_f),
    .instr_f     (instr_f),
    .pc_f        (pc_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_addr(output logic [31:0] v);
    if (exp_addr_q.size() == 0) begin
      check("addr_q_empty", 32'd0, 32'd1);
      v = '0;
    end else v = exp_addr_q.pop_front();
  endtask

  task automatic pop_pc(output logic [31:0] v);
    if (exp_pc_q.size() == 0) begin
      check("pc_q_empty", 32'd0, 32'd1);
      v = '0;
    end else v = exp_pc_q.pop_front();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  // One complete fetch: REQ (optional gnt stall) -> WAIT (optional redirect)
  // -> HOLD (optional stall, redirect while stalled, redirect at transfer)
  task automatic run_fetch(input int gnt_stall, input int hold, input bit check_ival,
                           input bit w_redir, input logic [31:0] w_npc,
                           input bit s_redir, input logic [31:0] s_npc,
                           input bit x_redir, input logic [31:0] x_npc,
                           input logic [31:0] exp_next);
    logic [31:0] e, p;
    bit ok;
    wait_req(ok);
    if (!ok) return;
    if (check_ival && have_last) check("issue_ival", cyc_cnt - last_start, 32'd3);
    last_start = cyc_cnt;
    have_last  = 1'b1;
    pop_addr(e);
    check("imem_addr", imem_addr, e);
    for (int i = 0; i < gnt_stall; i++) begin
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
      step();
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_held", imem_addr, e);
    end
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("wait_noreq", {31'd0, imem_req}, 32'd0);
    if (w_redir) begin
      redirect = 1'b1; npc_in = w_npc;
      step();
      redirect = 1'b0; npc_in = 32'hDEAD_BEEF;
    end
    exp_pc_q.push_back(e);
    imem_rvalid = 1'b1; imem_rdata = instr_of(e);
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_0002;
    pop_pc(p);
    check("valid_f", {31'd0, valid_f}, 32'd1);
    check("pc_f", pc_f, p);
    check("instr_f", instr_f, instr_of(p));
    for (int i = 0; i < hold; i++) begin
      ready_d = 1'b0;
      imem_rvalid = 1'b1; imem_gnt = 1'b1; imem_rdata = 32'hBAD0_0003;
      if (i == 0 && s_redir) begin
        redirect = 1'b1; npc_in = s_npc;
      end
      step();
      redirect = 1'b0; npc_in = 32'hDEAD_BEEF;
      check("hold_valid", {31'd0, valid_f}, 32'd1);
      check("hold_pc", pc_f, p);
      check("hold_instr", instr_f, instr_of(p));
      check("hold_noreq", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    ready_d = 1'b1;
    if (x_redir) begin
      redirect = 1'b1; npc_in = x_npc;
    end
    exp_addr_q.push_back(exp_next);
    step();
    ready_d = 1'b0; redirect = 1'b0; npc_in = 32'hDEAD_BEEF;
    check("xfer_clr", {31'd0, valid_f}, 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    bit ok;
    reset = 1'b0; npc_in = '0; redirect = 1'b0; ready_d = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_valid", {31'd0, valid_f}, 32'd0);
    check("rst_instr", instr_f, 32'd0);
    check("rst_pc_f", pc_f, 32'd0);
    reset = 1'b1;
    exp_addr_q.push_back(32'h0000_3000);

    // Back-to-back sequential fetches, then redirect at the transfer edge
    run_fetch(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_3004);
    run_fetch(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_3008);
    run_fetch(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_300C);
    run_fetch(0, 0, 1, 0, 0, 0, 0, 1, 32'h0000_3100, 32'h0000_3100);
    // Redirect during WAIT: delay slot delivered, pending target used next
    run_fetch(0, 0, 1, 1, 32'h0000_3200, 0, 0, 0, 0, 32'h0000_3200);
    run_fetch(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_3204);
    // Long HOLD stall; same-cycle redirect beats pending target
    run_fetch(0, 5, 0, 1, 32'h0000_3700, 0, 0, 1, 32'h0000_3208, 32'h0000_3208);
    // Two unconsumed redirects: latest wins, low bits cleared
    run_fetch(0, 2, 0, 1, 32'h0000_3300, 1, 32'h0000_3403, 0, 0, 32'h0000_3400);
    run_fetch(2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_3404);

    // Reset in WAIT with a pending redirect
    wait_req(ok);
    pop_addr(e);
    check("imem_addr", imem_addr, e);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; npc_in = 32'h0000_3500;
    step();
    reset = 1'b0; redirect = 1'b1; npc_in = 32'h0000_3600;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0004; ready_d = 1'b1;
    step();
    reset = 1'b1; redirect = 1'b0; imem_rvalid = 1'b0; ready_d = 1'b0;
    check("mid_rst_req", {31'd0, imem_req}, 32'd1);
    check("mid_rst_addr", imem_addr, 32'h0000_3000);
    check("mid_rst_valid", {31'd0, valid_f}, 32'd0);
    exp_addr_q.delete();
    exp_pc_q.delete();
    exp_addr_q.push_back(32'h0000_3000);
    have_last = 1'b0;
    run_fetch(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_3004);
    // Address wrap at the top of memory
    run_fetch(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run_fetch(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
    run_fetch(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004);
    wait_req(ok);
    pop_addr(e);
    check("final_addr", imem_addr, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
